seg7_time_display: RTL

- Reader side of the stopwatch time bus. Consumes the Counter's 8-bit BCD `time_reading` (tens in [7:4], ones in [3:0]).
- Drives the BASYS3 4-digit common-anode seven-segment display by time-multiplexing the anodes.
- Adds a per-slot anti-ghosting blank interval.
- Takes a frame-coherent snapshot of the time value, so a digit never tears mid-frame.

---
 rtl/seg7_pkg.sv | 32 +++
 rtl/bcd_to_seg7.sv | 33 +++
 rtl/seg7_time_display.sv | 104 ++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg: segment patterns, anode constant and FSM encoding for the display
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seg7_pkg;

  // Active-low cathode patterns, bit order g f e d c b a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7: combinational BCD to active-low seven-segment decoder
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg7_time_display.sv
// ---------------------------------------------------------------------------
// seg7_time_display: multiplexed 2-digit BCD time display with per-slot
// blanking and frame-coherent snapshot. Option: SEG7_LEADING_ZERO_BLANK_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg7_time_display
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       init_regs,
  input  logic [7:0] time_reading,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_BLANK    = CNT_W'(BLANK_CYCLES);

  if (DIGIT_CYCLES < 2 || BLANK_CYCLES >= DIGIT_CYCLES || BLANK_CYCLES < 0) begin : g_bad_params
    $error("seg7_time_display: need DIGIT_CYCLES >= 2 and 0 <= BLANK_CYCLES < DIGIT_CYCLES");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  state_e           state_q, state_d;
  logic [7:0]       snap_q, snap_d;
  logic             first_q;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       nib;
  logic [6:0]       nib_seg;
  logic             show;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == C_CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
    state_d = (cnt_d < C_BLANK) ? BLANK : DRIVE;
    // Reload only at frame start, and once right after reset so frame 0 is live
    snap_d = snap_q;
    if (first_q || (cnt_d == '0 && idx_d == 2'd0)) begin
      snap_d = time_reading;
    end
  end

  assign nib = idx_q[0] ? snap_q[7:4] : snap_q[3:0];

  bcd_to_seg7 u_dec (
    .bcd_i (nib),
    .seg_o (nib_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  assign show = !(idx_q == 2'd1 && snap_q[7:4] == 4'd0);
`else
  assign show = 1'b1;
`endif

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    if (state_q == DRIVE && !idx_q[1] && show) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = nib_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (init_regs) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      state_q <= BLANK;
      snap_q  <= 8'h00;
      first_q <= 1'b1;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      snap_q  <= snap_d;
      first_q <= 1'b0;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

`default_nettype wire
